demux_1x4_stream: RTL and testbench



---
 rtl/demux_1x4_stream_pkg.sv | 9 +
 rtl/demux_1x4_stream_slot.sv | 45 ++++
 rtl/demux_1x4_stream.sv | 45 ++++
 tb/tb_demux_1x4_stream.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/demux_1x4_stream_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
package demux_1x4_stream_pkg;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    typedef logic [1:0] ch_sel_t;

endpackage

// File: rtl/demux_1x4_stream_slot.sv
// One-entry register slice for a single output channel, with a
// wrapping count of words delivered to its consumer.
module demux_slot
    import demux_1x4_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count
);

    logic take;
    logic give;

    // A full slot can refill in the same cycle it drains, so there is no bubble.
    assign in_ready = rst_n && (!out_valid || out_ready);
    assign take     = in_valid && in_ready;
    assign give     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            if (give) begin
                out_count <= out_count + 1'b1;
            end
            if (take) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end else if (give) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/demux_1x4_stream.sv
// Registered 1-to-4 stream demultiplexer; each channel owns a one-entry
// slot so a stalled consumer only back-pressures words addressed to it.
module demux_1x4_stream
    import demux_1x4_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_sel,
    input  logic [WIDTH-1:0]        in_data,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [NUM_CH*CNT_W-1:0] out_count
);

    ch_sel_t           sel;
    logic [NUM_CH-1:0] slot_valid;
    logic [NUM_CH-1:0] slot_ready;

    assign sel      = ch_sel_t'(in_sel);
    assign in_ready = slot_ready[sel];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        assign slot_valid[k] = in_valid && (sel == ch_sel_t'(k));

        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (slot_valid[k]),
            .in_ready  (slot_ready[k]),
            .in_data   (in_data),
            .out_valid (out_valid[k]),
            .out_ready (out_ready[k]),
            .out_data  (out_data[k*WIDTH +: WIDTH]),
            .out_count (out_count[k*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Directed, table-driven bench for demux_1x4_stream with hand-computed expectations.
module tb_demux_1x4_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [7:0]  in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [31:0] out_count;

    int checks   = 0;
    int failures = 0;

    demux_1x4_stream #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [1:0]  sel;
        logic [7:0]  data;
        logic [3:0]  rdy;
        logic        exp_ready;
        logic [3:0]  exp_valid;
        logic [31:0] exp_data;
        logic [31:0] exp_count;
    } vec_t;

    vec_t vecs[15];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle: check in_ready before the edge, registered outputs after it.
    task automatic applyStimulus(input vec_t v, input string name);
        in_valid  = v.vld;
        in_sel    = v.sel;
        in_data   = v.data;
        out_ready = v.rdy;
        #2;
        checkOutput({name, " in_ready"}, {31'b0, in_ready}, {31'b0, v.exp_ready});
        @(posedge clk);
        #1;
        checkOutput({name, " out_valid"}, {28'b0, out_valid}, {28'b0, v.exp_valid});
        checkOutput({name, " out_data"}, out_data, v.exp_data);
        checkOutput({name, " out_count"}, out_count, v.exp_count);
    endtask

    initial begin
        logic [31:0] exp_count;
        logic [7:0]  byte_i;
        vec_t        v;

        // Sequential fill with all consumers ready, then ch2 stall, ch1 stall, ch0 refill.
        vecs[0]  = '{1'b1, 2'd0, 8'hA0, 4'hF, 1'b1, 4'b0001, 32'h000000A0, 32'h00000000};
        vecs[1]  = '{1'b1, 2'd1, 8'hA1, 4'hF, 1'b1, 4'b0010, 32'h0000A1A0, 32'h00000001};
        vecs[2]  = '{1'b1, 2'd2, 8'hA2, 4'hF, 1'b1, 4'b0100, 32'h00A2A1A0, 32'h00000101};
        vecs[3]  = '{1'b1, 2'd3, 8'hA3, 4'hF, 1'b1, 4'b1000, 32'hA3A2A1A0, 32'h00010101};
        vecs[4]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'hA3A2A1A0, 32'h01010101};
        vecs[5]  = '{1'b1, 2'd2, 8'h11, 4'hB, 1'b1, 4'b0100, 32'hA311A1A0, 32'h01010101};
        vecs[6]  = '{1'b1, 2'd2, 8'h22, 4'hB, 1'b0, 4'b0100, 32'hA311A1A0, 32'h01010101};
        vecs[7]  = '{1'b1, 2'd2, 8'h22, 4'hF, 1'b1, 4'b0100, 32'hA322A1A0, 32'h01020101};
        vecs[8]  = '{1'b0, 2'd2, 8'h00, 4'hF, 1'b1, 4'b0000, 32'hA322A1A0, 32'h01030101};
        vecs[9]  = '{1'b1, 2'd1, 8'h33, 4'hD, 1'b1, 4'b0010, 32'hA32233A0, 32'h01030101};
        vecs[10] = '{1'b1, 2'd3, 8'h55, 4'hD, 1'b1, 4'b1010, 32'h552233A0, 32'h01030101};
        vecs[11] = '{1'b1, 2'd1, 8'h66, 4'hD, 1'b0, 4'b0010, 32'h552233A0, 32'h02030101};
        vecs[12] = '{1'b1, 2'd0, 8'h44, 4'hC, 1'b1, 4'b0011, 32'h55223344, 32'h02030101};
        vecs[13] = '{1'b1, 2'd0, 8'h77, 4'hD, 1'b1, 4'b0011, 32'h55223377, 32'h02030102};
        vecs[14] = '{1'b0, 2'd1, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h55223377, 32'h02030203};

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        in_data   = 8'h00;
        out_ready = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset in_ready", {31'b0, in_ready}, 32'h0);
        checkOutput("reset out_valid", {28'b0, out_valid}, 32'h0);
        checkOutput("reset out_data", out_data, 32'h0);
        checkOutput("reset out_count", out_count, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Stream 256 words into ch1; the counter passes through FF -> 00 on the way.
        exp_count = 32'h02030203;
        for (int i = 0; i < 256; i++) begin
            byte_i = 8'(i);
            in_valid  = 1'b1;
            in_sel    = 2'd1;
            in_data   = byte_i;
            out_ready = 4'hF;
            #2;
            checkOutput("stream in_ready", {31'b0, in_ready}, 32'h1);
            @(posedge clk);
            #1;
            if (i > 0) exp_count[15:8] = exp_count[15:8] + 8'd1;
            checkOutput("stream ch1 data", {24'b0, out_data[15:8]}, {24'b0, byte_i});
            checkOutput("stream out_count", out_count, exp_count);
        end
        v = '{1'b0, 2'd1, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h5522FF77, 32'h02030203};
        applyStimulus(v, "wrap drain");

        // Fill every slot with consumers stalled, then reset with all four full.
        v = '{1'b1, 2'd0, 8'h81, 4'h0, 1'b1, 4'b0001, 32'h5522FF81, 32'h02030203};
        applyStimulus(v, "fill0");
        v = '{1'b1, 2'd1, 8'h82, 4'h0, 1'b1, 4'b0011, 32'h55228281, 32'h02030203};
        applyStimulus(v, "fill1");
        v = '{1'b1, 2'd2, 8'h83, 4'h0, 1'b1, 4'b0111, 32'h55838281, 32'h02030203};
        applyStimulus(v, "fill2");
        v = '{1'b1, 2'd3, 8'h84, 4'h0, 1'b1, 4'b1111, 32'h84838281, 32'h02030203};
        applyStimulus(v, "fill3");

        in_valid  = 1'b1;
        in_sel    = 2'd2;
        out_ready = 4'hF;
        rst_n     = 1'b0;
        #2;
        checkOutput("midreset in_ready", {31'b0, in_ready}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("midreset out_valid", {28'b0, out_valid}, 32'h0);
        checkOutput("midreset out_data", out_data, 32'h0);
        checkOutput("midreset out_count", out_count, 32'h0);
        checkOutput("midreset in_ready held", {31'b0, in_ready}, 32'h0);
        rst_n = 1'b1;

        v = '{1'b1, 2'd3, 8'h99, 4'h0, 1'b1, 4'b1000, 32'h99000000, 32'h00000000};
        applyStimulus(v, "post reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
